// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Also provides the leading-zero blanking helper used when BCD_LEADING_BLANK_EN is defined.
package bcd_pkg;

   localparam int         BCD_DIGITS = 3;
   localparam int         BCD_W      = 12;
   localparam logic [3:0] BCD_BLANK  = 4'hF;

   typedef logic [BCD_W-1:0] bcd3_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } cvt_state_t;

   // Leading zeros become BCD_BLANK; the units digit always stays visible.
   function automatic bcd3_t blank_leading(input bcd3_t i_bcd);
      bcd3_t r_res;
      r_res = i_bcd;
      if (i_bcd[11:8] == 4'd0) begin
         r_res[11:8] = BCD_BLANK;
         if (i_bcd[7:4] == 4'd0) begin
            r_res[7:4] = BCD_BLANK;
         end else begin
            r_res[7:4] = i_bcd[7:4];
         end
      end else begin
         r_res[11:8] = i_bcd[11:8];
      end
      return r_res;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit cell: a BCD digit of 5 or more gets +3 before the shift.
// A legal input (<= 9) can never carry out of the 4-bit result.
module bcd_add3 (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   // Conditional add-3 adjust.
   always_comb begin
      o_digit = i_digit;
      if (i_digit >= 4'd5) begin
         o_digit = i_digit + 4'd3;
      end else begin
         o_digit = i_digit;
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 converter, unsigned BIN_W-bit binary to 3-digit packed BCD.
// Optional macro BCD_LEADING_BLANK_EN: blank leading zero digits with 4'hF on the result.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output bcd3_t            bcd_out
);

   localparam int SR_W = BCD_W + BIN_W;

   generate
      if (BIN_W < 4 || BIN_W > 9) begin : g_bad_width
         $error("bin_to_bcd_seq: BIN_W must be within 4..9");
      end
   endgenerate

   cvt_state_t      r_state;
   logic [SR_W-1:0] r_sr;
   logic [3:0]      r_cnt;
   bcd3_t           w_adj;
   logic [SR_W-1:0] w_sr_next;
   bcd3_t           w_result;

   generate
      for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
         bcd_add3 u_add3 (
            .i_digit (r_sr[BIN_W + 4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
         );
      end
   endgenerate

   // The adjusted hundreds MSB is always zero for legal widths, so dropping it is lossless.
   assign w_sr_next = {w_adj[BCD_W-2:0], r_sr[BIN_W-1:0], 1'b0};

`ifdef BCD_LEADING_BLANK_EN
   assign w_result = blank_leading(r_sr[SR_W-1 -: BCD_W]);
`else
   assign w_result = r_sr[SR_W-1 -: BCD_W];
`endif

   // Conversion FSM; bcd_out only moves in DONE so the display never sees partial results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sr    <= {SR_W{1'b0}};
         r_cnt   <= 4'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd_out <= 12'h000;
      end else begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_sr    <= {{BCD_W{1'b0}}, bin_in};
                  r_cnt   <= 4'(BIN_W);
                  busy    <= 1'b1;
                  r_state <= SHIFT;
               end else begin
                  r_state <= IDLE;
               end
            end
            SHIFT: begin
               r_sr  <= w_sr_next;
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= DONE;
               end else begin
                  r_state <= SHIFT;
               end
            end
            DONE: begin
               bcd_out <= w_result;
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
